// File: rtl/game_types_pkg.sv
// Shared game types: operation codes, PS/2 scancode constants and the
// make-code lookup helpers used by the keyboard front end.
package game_types_pkg;

  typedef enum logic [2:0] {
    OP_W     = 3'b000,
    OP_A     = 3'b001,
    OP_S     = 3'b010,
    OP_D     = 3'b011,
    OP_SPACE = 3'b100,
    OP_Z     = 3'b101,
    OP_NONE  = 3'b110
  } op_e;

  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_Z      = 8'h1A;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  typedef struct packed {
    logic hit;
    op_e  op;
  } op_lookup_t;

  function automatic op_lookup_t map_main(input logic [7:0] sc);
    op_lookup_t r;
    r = '{hit: 1'b1, op: OP_NONE};
    case (sc)
      SC_W:     r.op = OP_W;
      SC_A:     r.op = OP_A;
      SC_S:     r.op = OP_S;
      SC_D:     r.op = OP_D;
      SC_SPACE: r.op = OP_SPACE;
      SC_Z:     r.op = OP_Z;
      default:  r.hit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic op_lookup_t map_arrow(input logic [7:0] sc);
    op_lookup_t r;
    r = '{hit: 1'b1, op: OP_NONE};
    case (sc)
      SC_UP:    r.op = OP_W;
      SC_LEFT:  r.op = OP_A;
      SC_DOWN:  r.op = OP_S;
      SC_RIGHT: r.op = OP_D;
      default:  r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: input synchronisers, falling-edge detect, 11-bit frame
// shifter with start/parity/stop check, and partial-frame timeout.
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error,
  output logic       check_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [10:0]            shift_q, shift_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic [7:0]             byte_q, byte_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   frame_error_q, frame_error_d;
  logic                   check_error_q, check_error_d;
  logic                   fall;
  logic [10:0]            frame;

  // Next-state: synchronise, detect falling edge, shift bits, check frame, time out.
  always_comb begin
    clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], ps2_clock};
    dat_sync_d    = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d    = clk_sync_q[SYNC_STAGES-1];
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    byte_d        = byte_q;
    byte_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    check_error_d = 1'b0;
    fall  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    // Bits arrive LSB first, so after 11 shifts bit 0 is start and bit 10 stop.
    frame = {dat_sync_q[SYNC_STAGES-1], shift_q[10:1]};
    if (fall) begin
      idle_cnt_d = '0;
      shift_d    = frame;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        if (!frame[0] && frame[10] && (^frame[9:1])) begin
          byte_valid_d = 1'b1;
          byte_d       = frame[8:1];
        end else begin
          frame_error_d = 1'b1;
          check_error_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else begin
      if (idle_cnt_q != CNT_W'(TIMEOUT_CYCLES))
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      if ((idle_cnt_q == CNT_W'(TIMEOUT_CYCLES)) && (bit_cnt_q != '0)) begin
        bit_cnt_d     = '0;
        frame_error_d = 1'b1;
      end
    end
  end

  // State registers; PS/2 lines idle high.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync_q    <= '1;
      dat_sync_q    <= '1;
      clk_prev_q    <= 1'b1;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      byte_q        <= '0;
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      check_error_q <= 1'b0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      dat_sync_q    <= dat_sync_d;
      clk_prev_q    <= clk_prev_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      byte_q        <= byte_d;
      byte_valid_q  <= byte_valid_d;
      frame_error_q <= frame_error_d;
      check_error_q <= check_error_d;
    end
  end

  assign rx_byte     = byte_q;
  assign byte_valid  = byte_valid_q;
  assign frame_error = frame_error_q;
  assign check_error = check_error_q;

endmodule

// File: rtl/keyboard_decoder.sv
// Keyboard decoder: PS/2 receive, break/extended prefix filter, scancode
// lookup and ready/read-fin handshake with a one-entry pending slot.
// Optional macro KEYBOARD_ARROW_KEYS_EN maps E0-prefixed arrow keys.
module keyboard_decoder
  import game_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       keyboard_read_fin,
  output logic       keyboard_ready,
  output logic [2:0] keyboard_data,
  output logic       frame_error
);

  typedef enum logic [1:0] {HS_IDLE, HS_PRESENT, HS_WAIT_ACK_LOW} hs_e;

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       check_error;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .ps2_clock  (ps2_clock),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_error(frame_error),
    .check_error(check_error)
  );

  logic       break_q, break_d;
  logic       ext_q, ext_d;
  logic       code_valid_q, code_valid_d;
  op_e        code_q, code_d;
  op_lookup_t lk;

  // Prefix filter and lookup: produces at most one decoded code per byte.
  always_comb begin
    break_d      = break_q;
    ext_d        = ext_q;
    code_valid_d = 1'b0;
    code_d       = OP_NONE;
    lk           = '{hit: 1'b0, op: OP_NONE};
    if (check_error) begin
      break_d = 1'b0;
      ext_d   = 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == SC_BREAK) begin
        break_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        break_d = 1'b0;
        ext_d   = 1'b0;
        if (!break_q) begin
          if (ext_q) begin
`ifdef KEYBOARD_ARROW_KEYS_EN
            lk = map_arrow(rx_byte);
`else
            lk = '{hit: 1'b0, op: OP_NONE};
`endif
          end else begin
            lk = map_main(rx_byte);
          end
          code_valid_d = lk.hit;
          code_d       = lk.op;
        end
      end
    end
  end

  // Filter flags and the decoded-code stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      break_q      <= 1'b0;
      ext_q        <= 1'b0;
      code_valid_q <= 1'b0;
      code_q       <= OP_NONE;
    end else begin
      break_q      <= break_d;
      ext_q        <= ext_d;
      code_valid_q <= code_valid_d;
      code_q       <= code_d;
    end
  end

  hs_e state_q;
  logic ready_q;
  op_e  data_q;
  logic pend_valid_q;
  op_e  pend_q;

  // Handshake FSM: present, wait for read_fin, then wait for read_fin low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= HS_IDLE;
      ready_q      <= 1'b0;
      data_q       <= OP_NONE;
      pend_valid_q <= 1'b0;
      pend_q       <= OP_NONE;
    end else begin
      case (state_q)
        HS_IDLE: begin
          if (code_valid_q) begin
            if (keyboard_read_fin) begin
              pend_valid_q <= 1'b1;
              pend_q       <= code_q;
              state_q      <= HS_WAIT_ACK_LOW;
            end else begin
              ready_q <= 1'b1;
              data_q  <= code_q;
              state_q <= HS_PRESENT;
            end
          end
        end
        HS_PRESENT: begin
          if (keyboard_read_fin) begin
            ready_q <= 1'b0;
            data_q  <= OP_NONE;
            state_q <= HS_WAIT_ACK_LOW;
            if (code_valid_q) begin
              pend_valid_q <= 1'b1;
              pend_q       <= code_q;
            end
          end else if (code_valid_q) begin
            data_q <= code_q;
          end
        end
        HS_WAIT_ACK_LOW: begin
          // Leaving with a code skips IDLE so ready rises right after read_fin drops.
          if (!keyboard_read_fin) begin
            if (code_valid_q || pend_valid_q) begin
              ready_q      <= 1'b1;
              data_q       <= code_valid_q ? code_q : pend_q;
              pend_valid_q <= 1'b0;
              pend_q       <= OP_NONE;
              state_q      <= HS_PRESENT;
            end else begin
              state_q <= HS_IDLE;
            end
          end else if (code_valid_q) begin
            pend_valid_q <= 1'b1;
            pend_q       <= code_q;
          end
        end
        default: state_q <= HS_IDLE;
      endcase
    end
  end

  assign keyboard_ready = ready_q;
  assign keyboard_data  = data_q;

endmodule
